// File: rtl/pe_mesh.sv
// pe_mesh: ROWS x COLS mesh of A/B/S registers with a command FSM for shifts, MAC and fused Cannon steps
module pe_mesh #(
  parameter int ROWS             = 4,
  parameter int COLS             = 4,
  parameter int PRECISION        = 8,
  parameter int OUTPUT_PRECISION = 32,
  parameter int CNT_W            = 8
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst_n,
  input  logic                                     i_cmd_valid,
  output logic                                     o_cmd_ready,
  input  logic [2:0]                               i_cmd,
  input  logic [1:0]                               i_cmd_dir,
  input  logic [CNT_W-1:0]                         i_cmd_count,
  input  logic                                     i_wrap_en,
  input  logic [ROWS*COLS*PRECISION-1:0]           i_a_load,
  input  logic [ROWS*COLS*PRECISION-1:0]           i_b_load,
  input  logic [ROWS*COLS*OUTPUT_PRECISION-1:0]    i_s_load,
  output logic [ROWS*COLS*PRECISION-1:0]           o_a_out,
  output logic [ROWS*COLS*PRECISION-1:0]           o_b_out,
  output logic [ROWS*COLS*OUTPUT_PRECISION-1:0]    o_s_out,
  output logic                                     o_busy,
  output logic                                     o_done
);
  localparam int P  = PRECISION;
  localparam int OP = OUTPUT_PRECISION;
  localparam int NE = ROWS * COLS;
  localparam logic [2:0] C_NOP  = 3'd0;
  localparam logic [2:0] C_LOAD = 3'd1;
  localparam logic [2:0] C_SHA  = 3'd2;
  localparam logic [2:0] C_SHB  = 3'd3;
  localparam logic [2:0] C_MAC  = 3'd4;
  localparam logic [2:0] C_CLR  = 3'd5;
  localparam logic [2:0] C_SMAC = 3'd6;

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  state_t              r_state, w_state_nx;
  logic [2:0]          r_cmd;
  logic [1:0]          r_dir;
  logic                r_wrap;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_done;
  logic [NE*P-1:0]     r_a, r_b, w_a_nx, w_b_nx;
  logic [NE*OP-1:0]    r_s, w_s_nx;
  logic                w_accept, w_is_shift, w_last;

  assign w_accept   = i_cmd_valid & o_cmd_ready;
  assign w_is_shift = (i_cmd == C_SHA) || (i_cmd == C_SHB) || (i_cmd == C_SMAC);
  assign w_last     = r_cnt == '0;
  assign o_a_out    = r_a;
  assign o_b_out    = r_b;
  assign o_s_out    = r_s;
  assign o_done     = r_done;

  // next state: accept while idle, leave EXEC after the final step
  always_comb begin
    o_cmd_ready = r_state == S_IDLE;
    o_busy      = r_state == S_EXEC;
    w_state_nx  = o_cmd_ready ? (i_cmd_valid ? S_EXEC : S_IDLE) : (w_last ? S_IDLE : S_EXEC);
  end

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  // command holding registers, step counter and done pulse; a zero-count shift runs as a one-step NOP
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmd  <= C_NOP;
      r_dir  <= '0;
      r_wrap <= 1'b0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= o_busy && w_last;
      if (w_accept) begin
        r_cmd  <= (w_is_shift && i_cmd_count == '0) ? C_NOP : i_cmd;
        r_dir  <= i_cmd_dir;
        r_wrap <= i_wrap_en;
        r_cnt  <= (w_is_shift && i_cmd_count != '0) ? i_cmd_count - 1'b1 : '0;
      end else if (o_busy && !w_last) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // planes advance by one step on every EXEC edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a <= '0;
      r_b <= '0;
      r_s <= '0;
    end else if (o_busy) begin
      r_a <= w_a_nx;
      r_b <= w_b_nx;
      r_s <= w_s_nx;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int I  = r * COLS + c;
      localparam int IU = ((r + 1) % ROWS) * COLS + c;
      localparam int ID = ((r + ROWS - 1) % ROWS) * COLS + c;
      localparam int IL = r * COLS + (c + 1) % COLS;
      localparam int IR = r * COLS + (c + COLS - 1) % COLS;
      localparam bit EU = r == ROWS - 1;
      localparam bit ED = r == 0;
      localparam bit EL = c == COLS - 1;
      localparam bit ER = c == 0;
      logic [P-1:0]         w_au, w_ad, w_al, w_ar, w_bu, w_bd, w_bl, w_br, w_a_sh, w_b_sh;
      logic signed [OP-1:0] w_ae, w_be, w_prod;
      assign w_au   = (EU && !r_wrap) ? '0 : r_a[IU*P +: P];
      assign w_ad   = (ED && !r_wrap) ? '0 : r_a[ID*P +: P];
      assign w_al   = (EL && !r_wrap) ? '0 : r_a[IL*P +: P];
      assign w_ar   = (ER && !r_wrap) ? '0 : r_a[IR*P +: P];
      assign w_bu   = (EU && !r_wrap) ? '0 : r_b[IU*P +: P];
      assign w_bd   = (ED && !r_wrap) ? '0 : r_b[ID*P +: P];
      assign w_bl   = (EL && !r_wrap) ? '0 : r_b[IL*P +: P];
      assign w_br   = (ER && !r_wrap) ? '0 : r_b[IR*P +: P];
      assign w_a_sh = r_dir == 2'd0 ? w_au : r_dir == 2'd1 ? w_ad : r_dir == 2'd2 ? w_al : w_ar;
      assign w_b_sh = r_dir == 2'd0 ? w_bu : r_dir == 2'd1 ? w_bd : r_dir == 2'd2 ? w_bl : w_br;
      assign w_ae   = OP'($signed(r_a[I*P +: P]));
      assign w_be   = OP'($signed(r_b[I*P +: P]));
      assign w_prod = w_ae * w_be;
      assign w_a_nx[I*P +: P] = r_cmd == C_LOAD ? i_a_load[I*P +: P] :
                                r_cmd == C_SHA  ? w_a_sh :
                                r_cmd == C_SMAC ? w_al : r_a[I*P +: P];
      assign w_b_nx[I*P +: P] = r_cmd == C_LOAD ? i_b_load[I*P +: P] :
                                r_cmd == C_SHB  ? w_b_sh :
                                r_cmd == C_SMAC ? w_bu : r_b[I*P +: P];
      assign w_s_nx[I*OP +: OP] = r_cmd == C_LOAD ? i_s_load[I*OP +: OP] :
                                  (r_cmd == C_MAC || r_cmd == C_SMAC) ? r_s[I*OP +: OP] + w_prod :
                                  r_cmd == C_CLR ? '0 : r_s[I*OP +: OP];
    end
  end
endmodule

// File: doc/pe_mesh.md
# pe_mesh

Parametrised successor to the square PE array: a ROWS×COLS mesh of PE registers (A, B, accumulator S) driven by a command FSM with a valid/ready handshake. It supports multi-step shifts in any direction, a toroidal-wrap or zero-fill edge mode, element-wise signed MAC, and a fused shift-and-MAC step for Cannon-style matrix multiply. It sits between the matmul sequencer and the operand loaders.

## Interface
- ROWS, 4, mesh rows (≥1)
- COLS, 4, mesh columns (≥1)
- PRECISION, 8, A/B element width (signed two's complement)
- OUTPUT_PRECISION, 32, S element width (signed, ≥2·PRECISION)
- CNT_W, 8, width of step-count field
- Flattened buses: element (r,c) occupies bits [((r·COLS+c)+1)·W-1 : (r·COLS+c)·W], W = PRECISION or OUTPUT_PRECISION
- CLK  in  1  clock; single clock domain, rising edge
- RST_N  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FSM idle, command accepted on edge where cmd_valid&cmd_ready
- cmd  in  3  0 NOP, 1 LOAD, 2 SHIFT_A, 3 SHIFT_B, 4 MAC, 5 CLEAR_S, 6 SHIFT_MAC, 7 reserved (= NOP)
- cmd_dir  in  2  0 up (r←r+1), 1 down (r←r−1), 2 left (c←c+1), 3 right (c←c−1)
- cmd_count  in  CNT_W  step count for SHIFT_A/SHIFT_B/SHIFT_MAC
- wrap_en  in  1  1 toroidal wrap, 0 zero fill at edges
- a_load, b_load  in  ROWS·COLS·PRECISION  LOAD sources
- s_load  in  ROWS·COLS·OUTPUT_PRECISION  LOAD source
- a_out, b_out  out  ROWS·COLS·PRECISION  current A, B registers
- s_out  out  ROWS·COLS·OUTPUT_PRECISION  current S registers
- busy  out  1  command executing
- done  out  1  one-cycle pulse on completion

## Operation
- States: IDLE, EXEC. IDLE: cmd_ready=1, busy=0. Accept → capture cmd, cmd_dir, wrap_en, N into holding regs → EXEC.
- N = cmd_count for SHIFT_A/SHIFT_B/SHIFT_MAC, with cmd_count=0 treated as N=1 with no data change; N=1 for all others.
- EXEC performs one step per cycle, decrements step counter; on the edge of step N → IDLE, done←1 for one cycle.
- LOAD: A←a_load, B←b_load, S←s_load, sampled on the execution edge; sources held stable from accept to done.
- SHIFT_A / SHIFT_B: whole A (or B) plane moves one position per step in cmd_dir. Vacated edge takes the opposite edge value when wrap_en=1, else 0. S and the other plane unchanged.
- MAC: S[r][c] ← S + sext(A)·sext(B), modulo 2^OUTPUT_PRECISION.
- CLEAR_S: all S←0; A, B unchanged.
- SHIFT_MAC: per step, S += A·B using pre-step values; simultaneously A shifts left and B shifts up (cmd_dir ignored, wrap_en applies).
- NOP/reserved: no data change; done still pulses.
- Inputs are ignored while busy; cmd_ready=0 throughout EXEC.

## Timing
- Reset (async assert, any state): all A, B, S = 0; state IDLE; cmd_ready=1, busy=0, done=0. A pending command is dropped and done is not pulsed.
- Accept at edge k; data updates at edges k+1..k+N; done=1 and cmd_ready=1 in the cycle after edge k+N.
- A new command may be accepted in the done cycle, so back-to-back throughput is N+1 cycles per command.
- Outputs are registered and reflect each step on the cycle after its edge.
- Shift by ROWS (vertical) or COLS (horizontal) with wrap_en=1 restores the plane exactly.

## Test plan
- Reset: pulse RST_N low mid-idle with random prior state -> all *_out 0, cmd_ready=1, busy=0, done=0 immediately (asynchronous).
- ROWS=2, COLS=3, LOAD A=[[1,2,3],[4,5,6]], then SHIFT_A right, count 1: wrap_en=0 -> [[0,1,2],[0,4,5]]; wrap_en=1 -> [[3,1,2],[6,4,5]]. done in the cycle after edge k+1.
- ROWS=2, SHIFT_B up, count=3, wrap_en=1, B=[[1,2,3],[4,5,6]] -> [[4,5,6],[1,2,3]]; busy=1 and cmd_ready=0 for 3 cycles; cmd_valid held high during busy is not re-accepted.
- MAC: A=0xFD (−3), B=7, S=10 -> S=0xFFFFFFF5. S=0x7FFFFFFF, A=1, B=1 -> 0x80000000 (wraps).
- 2×2 Cannon: LOAD A=[[1,2],[4,3]], B=[[5,8],[7,6]], S=0, then SHIFT_MAC count 2 wrap_en=1 -> S=[[19,22],[43,50]], A=[[1,2],[4,3]], B=[[5,8],[7,6]].
- Accept SHIFT_A count 5, assert RST_N low after 2 steps -> all planes 0 at once, no done pulse; after release, a NOP is accepted and done pulses once.
